// File: rtl/match_score_scheduler_pkg.sv
// Shared types and constants for the match score scheduler slice.
// Package name: score_sched_pkg.
package score_sched_pkg;

    // Scheduler control states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        SEND = 2'd2
    } state_e;

    localparam int unsigned SCORE_WIDTH_DEFAULT = 32;
    typedef logic [SCORE_WIDTH_DEFAULT-1:0] score_t;

    localparam logic [7:0] OVERRUN_MAX = 8'd255;

    // Saturating increment for the dropped-round counter
    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == OVERRUN_MAX) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/match_score_scheduler_argmax.sv
// Sequential argmax unit: one unsigned compare per cycle over a score bank.
// start_i loads entry 0 as the running best; indices 1..NUM_FILTERS-1 are
// then read through rd_idx_o/rd_data_i. done_o pulses the cycle after the
// last compare, with index_o/score_o holding the final result until the
// next start. Ties keep the lower index (strict greater-than only).
module score_argmax_seq
    import score_sched_pkg::*;
#(
    parameter int unsigned NUM_FILTERS = 10,
    parameter int unsigned SCORE_WIDTH = 32,
    parameter int unsigned IDX_WIDTH   = $clog2(NUM_FILTERS)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start_i,
    input  logic [SCORE_WIDTH-1:0] init_score_i,
    output logic [IDX_WIDTH-1:0]   rd_idx_o,
    input  logic [SCORE_WIDTH-1:0] rd_data_i,
    output logic                   done_o,
    output logic [IDX_WIDTH-1:0]   index_o,
    output logic [SCORE_WIDTH-1:0] score_o
);

    localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(NUM_FILTERS - 1);

    logic                   active_q, active_d;
    logic                   done_q, done_d;
    logic [IDX_WIDTH-1:0]   idx_q, idx_d;
    logic [IDX_WIDTH-1:0]   best_idx_q, best_idx_d;
    logic [SCORE_WIDTH-1:0] best_q, best_d;

    // Next-state: load on start, otherwise compare one bank entry per cycle
    always_comb begin
        active_d   = active_q;
        done_d     = 1'b0;
        idx_d      = idx_q;
        best_idx_d = best_idx_q;
        best_d     = best_q;
        if (start_i) begin
            active_d   = 1'b1;
            idx_d      = IDX_WIDTH'(1);
            best_idx_d = '0;
            best_d     = init_score_i;
        end else if (active_q) begin
            if (rd_data_i > best_q) begin
                best_d     = rd_data_i;
                best_idx_d = idx_q;
            end
            if (idx_q == LAST_IDX) begin
                active_d = 1'b0;
                done_d   = 1'b1;
            end else begin
                idx_d = idx_q + IDX_WIDTH'(1);
            end
        end
    end

    // Register running state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            active_q   <= 1'b0;
            done_q     <= 1'b0;
            idx_q      <= '0;
            best_idx_q <= '0;
            best_q     <= '0;
        end else begin
            active_q   <= active_d;
            done_q     <= done_d;
            idx_q      <= idx_d;
            best_idx_q <= best_idx_d;
            best_q     <= best_d;
        end
    end

    assign rd_idx_o = idx_q;
    assign done_o   = done_q;
    assign index_o  = best_idx_q;
    assign score_o  = best_q;

endmodule

// File: rtl/match_score_scheduler.sv
// Match score scheduler: latches a round of filter scores, finds the best
// filter with a sequential argmax, then streams a report over valid/ready.
// Optional macro SCORE_SCHED_BEST_ONLY_EN: report is only {best_index,
// best_score}; otherwise it is every bank entry followed by best_index.
module match_score_scheduler
    import score_sched_pkg::*;
#(
    parameter int unsigned NUM_FILTERS = 10,
    parameter int unsigned SCORE_WIDTH = 32,
    parameter int unsigned IDX_WIDTH   = $clog2(NUM_FILTERS)
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               scores_valid,
    input  logic [NUM_FILTERS*SCORE_WIDTH-1:0] scores,
    output logic                               busy,
    output logic                               best_valid,
    output logic [IDX_WIDTH-1:0]               best_index,
    output logic [SCORE_WIDTH-1:0]             best_score,
    output logic                               tx_valid,
    output logic [SCORE_WIDTH-1:0]             tx_data,
    input  logic                               tx_ready,
    output logic [7:0]                         overrun_count
);

    localparam int unsigned CNT_W = $clog2(NUM_FILTERS + 1);
`ifdef SCORE_SCHED_BEST_ONLY_EN
    localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(1);
`else
    localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(NUM_FILTERS);
`endif

    state_e                 state_q, state_d;
    logic [SCORE_WIDTH-1:0] bank_q [NUM_FILTERS];
    logic [SCORE_WIDTH-1:0] bank_d [NUM_FILTERS];
    logic [CNT_W-1:0]       word_q, word_d;
    logic                   tx_valid_q, tx_valid_d;
    logic [SCORE_WIDTH-1:0] tx_data_q, tx_data_d;
    logic                   best_valid_q, best_valid_d;
    logic [IDX_WIDTH-1:0]   best_idx_q, best_idx_d;
    logic [SCORE_WIDTH-1:0] best_score_q, best_score_d;
    logic [7:0]             ovr_q, ovr_d;

    logic                   am_start;
    logic [IDX_WIDTH-1:0]   am_rd_idx;
    logic                   am_done;
    logic [IDX_WIDTH-1:0]   am_index;
    logic [SCORE_WIDTH-1:0] am_score;

    logic [CNT_W-1:0]       word_sel;
    logic [IDX_WIDTH-1:0]   rep_idx;
`ifdef SCORE_SCHED_BEST_ONLY_EN
    logic [SCORE_WIDTH-1:0] rep_score;
`endif
    logic [SCORE_WIDTH-1:0] word_mux;

    score_argmax_seq #(
        .NUM_FILTERS (NUM_FILTERS),
        .SCORE_WIDTH (SCORE_WIDTH),
        .IDX_WIDTH   (IDX_WIDTH)
    ) u_argmax (
        .clk          (clk),
        .rst_n        (rst_n),
        .start_i      (am_start),
        .init_score_i (scores[SCORE_WIDTH-1:0]),
        .rd_idx_o     (am_rd_idx),
        .rd_data_i    (bank_q[am_rd_idx]),
        .done_o       (am_done),
        .index_o      (am_index),
        .score_o      (am_score)
    );

    // Report word mux: word 0 when entering SEND (result straight from the
    // argmax unit, not yet registered), otherwise the word after word_q
    always_comb begin
        word_sel = (state_q == SEND) ? word_q + CNT_W'(1) : '0;
        rep_idx  = (state_q == SEND) ? best_idx_q : am_index;
`ifdef SCORE_SCHED_BEST_ONLY_EN
        rep_score = (state_q == SEND) ? best_score_q : am_score;
        word_mux  = (word_sel == '0) ? SCORE_WIDTH'(rep_idx) : rep_score;
`else
        if (word_sel < CNT_W'(NUM_FILTERS)) begin
            word_mux = bank_q[IDX_WIDTH'(word_sel)];
        end else begin
            word_mux = SCORE_WIDTH'(rep_idx);
        end
`endif
    end

    // Control FSM, bank capture, report sequencing and overrun counting
    always_comb begin
        state_d      = state_q;
        bank_d       = bank_q;
        word_d       = word_q;
        tx_valid_d   = tx_valid_q;
        tx_data_d    = tx_data_q;
        best_valid_d = 1'b0;
        best_idx_d   = best_idx_q;
        best_score_d = best_score_q;
        ovr_d        = ovr_q;
        am_start     = 1'b0;

        if (scores_valid && (state_q != IDLE)) begin
            ovr_d = sat_inc8(ovr_q);
        end

        case (state_q)
            IDLE: begin
                if (scores_valid) begin
                    for (int unsigned i = 0; i < NUM_FILTERS; i++) begin
                        bank_d[i] = scores[i*SCORE_WIDTH +: SCORE_WIDTH];
                    end
                    am_start = 1'b1;
                    state_d  = SCAN;
                end
            end
            SCAN: begin
                if (am_done) begin
                    best_valid_d = 1'b1;
                    best_idx_d   = am_index;
                    best_score_d = am_score;
                    tx_valid_d   = 1'b1;
                    tx_data_d    = word_mux;
                    word_d       = '0;
                    state_d      = SEND;
                end
            end
            SEND: begin
                if (tx_valid_q && tx_ready) begin
                    if (word_q == LAST_WORD) begin
                        tx_valid_d = 1'b0;
                        state_d    = IDLE;
                    end else begin
                        word_d    = word_q + CNT_W'(1);
                        tx_data_d = word_mux;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers, all cleared by asynchronous reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            for (int unsigned i = 0; i < NUM_FILTERS; i++) begin
                bank_q[i] <= '0;
            end
            word_q       <= '0;
            tx_valid_q   <= 1'b0;
            tx_data_q    <= '0;
            best_valid_q <= 1'b0;
            best_idx_q   <= '0;
            best_score_q <= '0;
            ovr_q        <= '0;
        end else begin
            state_q      <= state_d;
            bank_q       <= bank_d;
            word_q       <= word_d;
            tx_valid_q   <= tx_valid_d;
            tx_data_q    <= tx_data_d;
            best_valid_q <= best_valid_d;
            best_idx_q   <= best_idx_d;
            best_score_q <= best_score_d;
            ovr_q        <= ovr_d;
        end
    end

    assign busy          = (state_q != IDLE);
    assign best_valid    = best_valid_q;
    assign best_index    = best_idx_q;
    assign best_score    = best_score_q;
    assign tx_valid      = tx_valid_q;
    assign tx_data       = tx_data_q;
    assign overrun_count = ovr_q;

endmodule

// File: tb/tb_match_score_scheduler.sv
// Self-checking bench for match_score_scheduler with NUM_FILTERS=4.
module tb_match_score_scheduler;

    localparam int N = 4;
`ifdef SCORE_SCHED_BEST_ONLY_EN
    localparam int WORDS = 2;
`else
    localparam int WORDS = N + 1;
`endif

    logic          clk;
    logic          rst_n;
    logic          scores_valid;
    logic [N-1:0][31:0] scores;
    logic          busy;
    logic          best_valid;
    logic [1:0]    best_index;
    logic [31:0]   best_score;
    logic          tx_valid;
    logic [31:0]   tx_data;
    logic          tx_ready;
    logic [7:0]    overrun_count;

    int checks = 0;
    int errors = 0;

    logic [31:0] exp_q [$];
    bit          hold_pend = 0;
    logic [31:0] hold_data = '0;

    typedef struct {
        logic [N-1:0][31:0] s;
        int                 idx;
        logic [31:0]        score;
    } vec_t;

    vec_t vecs [6];

    match_score_scheduler #(
        .NUM_FILTERS (N),
        .SCORE_WIDTH (32),
        .IDX_WIDTH   (2)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .scores_valid  (scores_valid),
        .scores        (scores),
        .busy          (busy),
        .best_valid    (best_valid),
        .best_index    (best_index),
        .best_score    (best_score),
        .tx_valid      (tx_valid),
        .tx_data       (tx_data),
        .tx_ready      (tx_ready),
        .overrun_count (overrun_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: pop on each handshake, and check data stability under stall
    always @(negedge clk) begin
        if (!rst_n) begin
            hold_pend = 0;
        end else begin
            if (hold_pend) begin
                chk("tx_hold_valid", {31'd0, tx_valid}, 32'd1);
                chk("tx_hold_data", tx_data, hold_data);
            end
            if (tx_valid && tx_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL tx_extra actual=%0d required=none", tx_data);
                end else begin
                    chk("tx_word", tx_data, exp_q.pop_front());
                end
            end
            hold_pend = tx_valid && !tx_ready;
            hold_data = tx_data;
        end
    end

    // ovr_mode: 0 none, 1 one pulse in SCAN and one in SEND, 2 pulse every SEND cycle
    task automatic run_round(input logic [N-1:0][31:0] s, input int exp_idx,
                             input logic [31:0] exp_score, input int stall_word,
                             input int stall_len, input int ovr_mode, input int rst_word);
        int  c;
        int  k;
        int  stalled;
        int  cyc;
        int  exp_stall;
        bit  hs;
        bit  seen;

        c = 0;
        while (busy && c < 2000) begin
            step();
            c++;
        end
        chk("idle_before_round", {31'd0, busy}, 32'd0);

        scores       = s;
        scores_valid = 1'b1;
`ifdef SCORE_SCHED_BEST_ONLY_EN
        exp_q.push_back(32'(exp_idx));
        exp_q.push_back(exp_score);
`else
        for (int i = 0; i < N; i++) exp_q.push_back(s[i]);
        exp_q.push_back(32'(exp_idx));
`endif
        step();
        scores_valid = 1'b0;
        scores       = {N{32'hDEAD_BEEF}};
        chk("busy_scan", {31'd0, busy}, 32'd1);

        seen = 0;
        for (c = 1; c <= 12; c++) begin
            scores_valid = (ovr_mode == 1) && (c == 2);
            step();
            scores_valid = 1'b0;
            if (best_valid) begin
                seen = 1;
                break;
            end
        end
        chk("best_latency", 32'(c), 32'd4);
        chk("best_index", {30'd0, best_index}, 32'(exp_idx));
        chk("best_score", best_score, exp_score);

        k = 0; stalled = 0; cyc = 0;
        exp_stall = (stall_word >= 0 && stall_word < WORDS) ? stall_len : 0;
        while (seen && exp_q.size() > 0 && cyc < 1000) begin
            if (rst_word >= 0 && k == rst_word) begin
                rst_n = 1'b0;
                #1;
                chk("rst_tx_valid", {31'd0, tx_valid}, 32'd0);
                chk("rst_busy", {31'd0, busy}, 32'd0);
                chk("rst_best_valid", {31'd0, best_valid}, 32'd0);
                chk("rst_best_index", {30'd0, best_index}, 32'd0);
                chk("rst_best_score", best_score, 32'd0);
                chk("rst_tx_data", tx_data, 32'd0);
                chk("rst_overrun", {24'd0, overrun_count}, 32'd0);
                exp_q.delete();
                #2;
                rst_n    = 1'b1;
                tx_ready = 1'b1;
                return;
            end
            tx_ready = !(k == stall_word && stalled < stall_len);
            if (!tx_ready) stalled++;
            scores_valid = ((ovr_mode == 1) && (cyc == 1)) || (ovr_mode == 2);
            hs = tx_valid && tx_ready;
            step();
            cyc++;
            scores_valid = 1'b0;
            if (cyc == 1) chk("best_pulse", {31'd0, best_valid}, 32'd0);
            if (hs) k++;
        end
        tx_ready = 1'b1;
        chk("send_cycles", 32'(cyc), 32'(WORDS + exp_stall));
        chk("word_count", 32'(k), 32'(WORDS));
        chk("tx_idle", {31'd0, tx_valid}, 32'd0);
        chk("busy_idle", {31'd0, busy}, 32'd0);
        chk("best_hold_index", {30'd0, best_index}, 32'(exp_idx));
    endtask

    initial begin
        #200000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

    initial begin
        vecs[0].s = {32'd5, 32'd25, 32'd40, 32'd10};          vecs[0].idx = 1; vecs[0].score = 32'd40;
        vecs[1].s = {32'd3, 32'd9, 32'd9, 32'd7};             vecs[1].idx = 1; vecs[1].score = 32'd9;
        vecs[2].s = {32'd5, 32'd5, 32'd5, 32'd5};             vecs[2].idx = 0; vecs[2].score = 32'd5;
        vecs[3].s = {32'hFFFF_FFFF, 32'd3, 32'd2, 32'd1};     vecs[3].idx = 3; vecs[3].score = 32'hFFFF_FFFF;
        vecs[4].s = {32'd0, 32'h7FFF_FFFF, 32'd0, 32'hFFFF_FFFF}; vecs[4].idx = 0; vecs[4].score = 32'hFFFF_FFFF;
        vecs[5].s = {32'd1, 32'd0, 32'd0, 32'd0};             vecs[5].idx = 3; vecs[5].score = 32'd1;

        rst_n        = 1'b0;
        scores_valid = 1'b0;
        scores       = '0;
        tx_ready     = 1'b1;
        #12;
        chk("reset_busy", {31'd0, busy}, 32'd0);
        chk("reset_tx_valid", {31'd0, tx_valid}, 32'd0);
        chk("reset_best_valid", {31'd0, best_valid}, 32'd0);
        chk("reset_best_score", best_score, 32'd0);
        chk("reset_tx_data", tx_data, 32'd0);
        chk("reset_overrun", {24'd0, overrun_count}, 32'd0);
        #2;
        rst_n = 1'b1;
        step();

        for (int v = 0; v < 6; v++) begin
            run_round(vecs[v].s, vecs[v].idx, vecs[v].score, -1, 0, 0, -1);
        end

        // Backpressure: three stall cycles while word 2 is presented
        run_round(vecs[0].s, 1, 32'd40, 2, 3, 0, -1);

        // Overruns during SCAN and SEND leave the report intact
        run_round(vecs[0].s, 1, 32'd40, -1, 0, 1, -1);
        chk("overrun_two", {24'd0, overrun_count}, 32'd2);

        // Asynchronous reset while word 2 is on the link, then a clean round
        run_round(vecs[0].s, 1, 32'd40, -1, 0, 0, (WORDS > 2) ? 2 : 1);
        step();
        run_round(vecs[1].s, 1, 32'd9, -1, 0, 0, -1);
        chk("overrun_after_reset", {24'd0, overrun_count}, 32'd0);

        // Saturation: hold word 0 for 300 cycles with scores_valid every cycle
        run_round(vecs[0].s, 1, 32'd40, 0, 300, 2, -1);
        chk("overrun_saturate", {24'd0, overrun_count}, 32'd255);
        chk("queue_empty", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
